// File: rtl/cache_line_fill_ctrl_if.sv
// Bundle between the cache-side miss interface, the narrow memory beat port
// and the fill controller. The controller holds the master view; the cache and
// memory (or a bench standing in for them) hold the slave view.
interface cache_line_fill_ctrl_if #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_SIZE_BITS = 512
);
  // cache side
  logic                      i_miss;
  logic [ADDRESS_WIDTH-1:0]  i_miss_addr;
  logic                      i_evict;
  logic [ADDRESS_WIDTH-1:0]  i_evict_addr;
  logic [LINE_SIZE_BITS-1:0] i_evict_data;
  logic [LINE_SIZE_BITS-1:0] o_memory_line;
  logic                      o_memory_response;
  logic                      o_busy;
  // memory side
  logic                      o_mem_req;
  logic                      o_mem_we;
  logic [ADDRESS_WIDTH-1:0]  o_mem_addr;
  logic [DATA_WIDTH-1:0]     o_mem_wdata;
  logic                      i_mem_ready;
  logic [DATA_WIDTH-1:0]     i_mem_rdata;
  logic                      i_mem_rvalid;

  modport master (
    input  i_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    input  i_mem_ready, i_mem_rdata, i_mem_rvalid,
    output o_memory_line, o_memory_response, o_busy,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport slave (
    output i_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    output i_mem_ready, i_mem_rdata, i_mem_rvalid,
    input  o_memory_line, o_memory_response, o_busy,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Miss-service stage between the set-associative cache and main memory.
// On a miss it optionally writes the dirty victim back beat by beat, then
// fetches the missing line over the narrow port, assembles it and returns it
// to the cache with a single-cycle response pulse.
module cache_line_fill_ctrl #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int OFFSET_BITS     = 6,
  parameter int DATA_WIDTH      = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  cache_line_fill_ctrl_if.master bus
);

  localparam int LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES;
  localparam int BEATS          = LINE_SIZE_BITS / DATA_WIDTH;
  localparam int IDX_W          = $clog2(BEATS);
  localparam int CNT_W          = IDX_W + 1;
  localparam int STRIDE_SHIFT   = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    {{(ADDRESS_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [CNT_W-1:0] BEATS_CNT = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] fill_base_reg;
  logic [ADDRESS_WIDTH-1:0] wb_base_reg;
  logic [CNT_W-1:0]         wb_cnt_reg;   // write-back beat index
  logic [CNT_W-1:0]         rq_cnt_reg;   // read requests accepted
  logic [CNT_W-1:0]         dq_cnt_reg;   // read beats returned
  logic [DATA_WIDTH-1:0]    evict_word_reg [BEATS];
  logic [DATA_WIDTH-1:0]    line_word_reg  [BEATS];
  logic [LINE_SIZE_BITS-1:0] line_flat;

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     resp;
  logic                     accept;
  logic                     rd_beat;
  logic                     capture;

  // Byte offset of beat n from the line base.
  function automatic logic [ADDRESS_WIDTH-1:0] beat_offset(input logic [CNT_W-1:0] n);
    return ADDRESS_WIDTH'(n) << STRIDE_SHIFT;
  endfunction

  assign accept  = mem_req & bus.i_mem_ready;
  // Returned data only counts while filling and until the line is complete.
  assign rd_beat = (state_reg == FILL) && bus.i_mem_rvalid && (dq_cnt_reg < BEATS_CNT);
  // A new miss is only taken in IDLE; later changes on the miss inputs are ignored.
  assign capture = (state_reg == IDLE) && bus.i_miss;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and memory-port outputs; request fields are pure functions of
  // registered state, so they hold steady through any number of stall cycles.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.i_miss) state_next = bus.i_evict ? WB : FILL;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_base_reg + beat_offset(wb_cnt_reg);
        mem_wdata = evict_word_reg[wb_cnt_reg[IDX_W-1:0]];
        if (bus.i_mem_ready && (wb_cnt_reg == LAST_CNT)) state_next = FILL;
      end
      FILL: begin
        if (rq_cnt_reg < BEATS_CNT) begin
          mem_req  = 1'b1;
          mem_addr = fill_base_reg + beat_offset(rq_cnt_reg);
        end
        if (rd_beat && (dq_cnt_reg == LAST_CNT)) state_next = RESP;
      end
      RESP: begin
        resp       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat counters: cleared in IDLE so every operation starts from beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cnt_reg <= '0;
      rq_cnt_reg <= '0;
      dq_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      wb_cnt_reg <= '0;
      rq_cnt_reg <= '0;
      dq_cnt_reg <= '0;
    end else begin
      if (state_reg == WB && accept)   wb_cnt_reg <= wb_cnt_reg + 1'b1;
      if (state_reg == FILL && accept) rq_cnt_reg <= rq_cnt_reg + 1'b1;
      if (rd_beat)                     dq_cnt_reg <= dq_cnt_reg + 1'b1;
    end
  end

  // Line-aligned base addresses latched when the miss is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_base_reg <= '0;
      wb_base_reg   <= '0;
    end else if (capture) begin
      fill_base_reg <= bus.i_miss_addr & LINE_MASK;
      if (bus.i_evict) wb_base_reg <= bus.i_evict_addr & LINE_MASK;
    end
  end

  // Per-word storage for the victim line and the line being assembled.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
      // Victim word gi, captured together with the miss.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      evict_word_reg[gi] <= '0;
        else if (capture && bus.i_evict) evict_word_reg[gi] <= bus.i_evict_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end

      // Fill word gi, written by the returned beat whose index matches.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          line_word_reg[gi] <= '0;
        else if (rd_beat && (dq_cnt_reg[IDX_W-1:0] == IDX_W'(gi)))
          line_word_reg[gi] <= bus.i_mem_rdata;
      end

      assign line_flat[gi*DATA_WIDTH +: DATA_WIDTH] = line_word_reg[gi];
    end
  endgenerate

  assign bus.o_mem_req         = mem_req;
  assign bus.o_mem_we          = mem_we;
  assign bus.o_mem_addr        = mem_addr;
  assign bus.o_mem_wdata       = mem_wdata;
  assign bus.o_memory_response = resp;
  assign bus.o_memory_line     = line_flat;
  assign bus.o_busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Directed bench for cache_line_fill_ctrl: a negedge-driven memory model
// returns read data one cycle after acceptance and logs every accepted beat;
// each scenario task drives a miss and checks the logs and outputs inline.
module tb_cache_line_fill_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_fill_ctrl_if bus ();

  cache_line_fill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // memory model state and logs
  logic [31:0] rdq[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] rd_addr[$];
  logic [31:0] tag = 32'h0;
  int seq, last_wr_seq, first_rd_seq, resp_cnt, rv_cnt, stab_err, stall_cnt;
  bit bp_mode = 1'b0;
  bit stray_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic prev_we;

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete(); rdq.delete();
    seq = 0; last_wr_seq = -1; first_rd_seq = -1;
    resp_cnt = 0; rv_cnt = 0; stab_err = 0;
  endtask

  // Memory model: everything happens on the falling edge.
  initial begin
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rdq.size() > 0) begin
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rdq.pop_front();
        rv_cnt++;
      end else if (stray_en && (!bus.o_busy || bus.o_mem_we)) begin
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hBAD0_BAD0;
      end else begin
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'h0;
      end
      if (stall_cnt > 0) begin
        bus.i_mem_ready = 1'b0;
        stall_cnt--;
      end else begin
        bus.i_mem_ready = 1'b1;
        if (bp_mode) stall_cnt = $urandom_range(1, 5);
      end
      if (rst_n && prev_stall &&
          (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== prev_addr ||
           bus.o_mem_we !== prev_we || bus.o_mem_wdata !== prev_wdata))
        stab_err++;
      prev_stall = rst_n && bus.o_mem_req && !bus.i_mem_ready;
      prev_addr  = bus.o_mem_addr;
      prev_we    = bus.o_mem_we;
      prev_wdata = bus.o_mem_wdata;
      if (rst_n && bus.o_mem_req && bus.i_mem_ready) begin
        seq++;
        if (bus.o_mem_we) begin
          wr_addr.push_back(bus.o_mem_addr);
          wr_data.push_back(bus.o_mem_wdata);
          last_wr_seq = seq;
        end else begin
          rd_addr.push_back(bus.o_mem_addr);
          rdq.push_back(tag + ((bus.o_mem_addr & 32'h3F) >> 2));
          if (first_rd_seq < 0) first_rd_seq = seq;
        end
      end
      if (rst_n && bus.o_memory_response) resp_cnt++;
    end
  end

  // Waits for the response pulse, then drops the miss after the response edge.
  task automatic wait_resp(input int budget, output int cyc, output bit timed_out);
    cyc = 0;
    timed_out = 1'b1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.o_memory_response === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!timed_out) begin
      @(posedge clk);
      #1;
      bus.i_miss  = 1'b0;
      bus.i_evict = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.i_miss = 1'b1;
    bus.i_miss_addr = 32'h0000_0100;
    #2;
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    total++; if (bus.o_mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.o_mem_req); end
    total++; if (bus.o_memory_response !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b want 0", bus.o_memory_response); end
    total++; if (bus.o_memory_line !== '0) begin bad++; $display("FAIL reset_line: got nonzero want 0"); end
    total++; if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_we} !== '0) begin bad++; $display("FAIL reset_port: addr %h wdata %h we %b want 0", bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_we); end
    bus.i_miss = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_clean_miss();
    int cyc, errs; bit to;
    clear_logs();
    tag = 32'hA000_0000;
    @(negedge clk);
    bus.i_miss = 1'b1; bus.i_miss_addr = 32'h0000_1234; bus.i_evict = 1'b0;
    wait_resp(100, cyc, to);
    $display("clean: miss 0x1234 served in %0d cycles", cyc);
    total++; if (to) begin bad++; $display("FAIL clean_timeout: got no response want pulse"); end
    total++; if (cyc != 18) begin bad++; $display("FAIL clean_latency: got %0d want 18", cyc); end
    total++; if (rd_addr.size() != 16 || wr_addr.size() != 0) begin bad++; $display("FAIL clean_count: got rd %0d wr %0d want 16 0", rd_addr.size(), wr_addr.size()); end
    errs = 0;
    for (int k = 0; k < rd_addr.size(); k++) if (rd_addr[k] !== 32'h1200 + 4*k) errs++;
    total++; if (errs != 0 || rd_addr[15] !== 32'h123C) begin bad++; $display("FAIL clean_addr: got %0d bad, last %h want 0, 0000123c", errs, rd_addr[15]); end
    total++; if (bus.o_memory_line[31:0] !== 32'hA000_0000) begin bad++; $display("FAIL clean_w0: got %h want a0000000", bus.o_memory_line[31:0]); end
    total++; if (bus.o_memory_line[511:480] !== 32'hA000_000F) begin bad++; $display("FAIL clean_w15: got %h want a000000f", bus.o_memory_line[511:480]); end
    repeat (4) @(negedge clk);
    total++; if (resp_cnt != 1 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL clean_once: got pulses %0d busy %b want 1 0", resp_cnt, bus.o_busy); end
  endtask

  task automatic test_evict();
    int cyc, errs; bit to;
    clear_logs();
    tag = 32'hC000_0000;
    for (int k = 0; k < 16; k++) bus.i_evict_data[k*32 +: 32] = 32'hD000_0000 + k;
    @(negedge clk);
    bus.i_miss = 1'b1; bus.i_miss_addr = 32'h0000_1200;
    bus.i_evict = 1'b1; bus.i_evict_addr = 32'h0000_8055;
    wait_resp(150, cyc, to);
    $display("evict: wb 0x8040 + fill 0x1200 served in %0d cycles", cyc);
    total++; if (to) begin bad++; $display("FAIL evict_timeout: got no response want pulse"); end
    total++; if (wr_addr.size() != 16 || rd_addr.size() != 16) begin bad++; $display("FAIL evict_count: got wr %0d rd %0d want 16 16", wr_addr.size(), rd_addr.size()); end
    errs = 0;
    for (int k = 0; k < wr_addr.size(); k++)
      if (wr_addr[k] !== 32'h8040 + 4*k || wr_data[k] !== 32'hD000_0000 + k) errs++;
    total++; if (errs != 0 || wr_addr[15] !== 32'h807C) begin bad++; $display("FAIL evict_wbeats: got %0d bad, last %h want 0, 0000807c", errs, wr_addr[15]); end
    total++; if (!(first_rd_seq > last_wr_seq)) begin bad++; $display("FAIL evict_order: got first read %0d last write %0d want read after", first_rd_seq, last_wr_seq); end
    total++; if (rd_addr[0] !== 32'h1200) begin bad++; $display("FAIL evict_rd0: got %h want 00001200", rd_addr[0]); end
    errs = 0;
    for (int k = 0; k < 16; k++) if (bus.o_memory_line[k*32 +: 32] !== 32'hC000_0000 + k) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL evict_line: got %0d bad words want 0", errs); end
  endtask

  task automatic test_backpressure();
    int cyc, errs; bit to;
    clear_logs();
    tag = 32'h5500_0000;
    bp_mode = 1'b1;
    for (int k = 0; k < 16; k++) bus.i_evict_data[k*32 +: 32] = 32'hE000_0000 + 3*k;
    @(negedge clk);
    bus.i_miss = 1'b1; bus.i_miss_addr = 32'h0000_3FC7;
    bus.i_evict = 1'b1; bus.i_evict_addr = 32'h0000_2000;
    wait_resp(1000, cyc, to);
    bp_mode = 1'b0;
    $display("backpressure: served in %0d cycles", cyc);
    total++; if (to) begin bad++; $display("FAIL bp_timeout: got no response want pulse"); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable: got %0d changes during stall want 0", stab_err); end
    total++; if (wr_addr.size() != 16 || rd_addr.size() != 16) begin bad++; $display("FAIL bp_count: got wr %0d rd %0d want 16 16", wr_addr.size(), rd_addr.size()); end
    errs = 0;
    for (int k = 0; k < wr_addr.size(); k++)
      if (wr_addr[k] !== 32'h2000 + 4*k || wr_data[k] !== 32'hE000_0000 + 3*k) errs++;
    for (int k = 0; k < rd_addr.size(); k++) if (rd_addr[k] !== 32'h3FC0 + 4*k) errs++;
    for (int k = 0; k < 16; k++) if (bus.o_memory_line[k*32 +: 32] !== 32'h5500_0000 + k) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_data: got %0d bad beats/words want 0", errs); end
  endtask

  task automatic test_reset_mid_fill();
    int cyc, errs; bit to;
    clear_logs();
    tag = 32'h7700_0000;
    @(negedge clk);
    bus.i_miss = 1'b1; bus.i_miss_addr = 32'h0000_4410;
    cyc = 0;
    while (rv_cnt < 5 && cyc < 100) begin @(negedge clk); cyc++; end
    total++; if (rv_cnt < 5) begin bad++; $display("FAIL midrst_wait: got %0d beats want 5", rv_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rdq.delete();
    total++; if (bus.o_busy !== 1'b0 || bus.o_mem_req !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: got busy %b req %b want 0 0", bus.o_busy, bus.o_mem_req); end
    total++; if (bus.o_memory_line !== '0 || bus.o_mem_addr !== '0) begin bad++; $display("FAIL midrst_data: got line word0 %h addr %h want 0 0", bus.o_memory_line[31:0], bus.o_mem_addr); end
    repeat (2) @(negedge clk);
    total++; if (resp_cnt != 0) begin bad++; $display("FAIL midrst_noresp: got %0d pulses want 0", resp_cnt); end
    clear_logs();
    rst_n = 1'b1;
    wait_resp(100, cyc, to);
    $display("midrst: refetch of 0x4400 served in %0d cycles", cyc);
    total++; if (to || resp_cnt != 1) begin bad++; $display("FAIL midrst_resp: got timeout %b pulses %0d want 0 1", to, resp_cnt); end
    total++; if (rd_addr.size() != 16 || rd_addr[0] !== 32'h4400) begin bad++; $display("FAIL midrst_restart: got %0d reads first %h want 16 00004400", rd_addr.size(), rd_addr[0]); end
    errs = 0;
    for (int k = 0; k < 16; k++) if (bus.o_memory_line[k*32 +: 32] !== 32'h7700_0000 + k) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL midrst_line: got %0d bad words want 0", errs); end
  endtask

  task automatic test_stray_rvalid();
    int cyc, errs; bit to;
    stray_en = 1'b1;
    repeat (4) @(negedge clk);
    errs = 0;
    for (int k = 0; k < 16; k++) if (bus.o_memory_line[k*32 +: 32] !== 32'h7700_0000 + k) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL stray_idle: got %0d words changed want 0", errs); end
    clear_logs();
    tag = 32'h3300_0000;
    for (int k = 0; k < 16; k++) bus.i_evict_data[k*32 +: 32] = 32'h6600_0000 + k;
    @(negedge clk);
    bus.i_miss = 1'b1; bus.i_miss_addr = 32'h0000_5500;
    bus.i_evict = 1'b1; bus.i_evict_addr = 32'h0000_9000;
    wait_resp(150, cyc, to);
    repeat (10) @(negedge clk);
    stray_en = 1'b0;
    $display("stray: wb 0x9000 + fill 0x5500 served in %0d cycles", cyc);
    total++; if (to || resp_cnt != 1 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL stray_once: got timeout %b pulses %0d busy %b want 0 1 0", to, resp_cnt, bus.o_busy); end
    total++; if (rd_addr.size() != 16 || wr_addr.size() != 16) begin bad++; $display("FAIL stray_count: got rd %0d wr %0d want 16 16", rd_addr.size(), wr_addr.size()); end
    errs = 0;
    for (int k = 0; k < 16; k++) if (bus.o_memory_line[k*32 +: 32] !== 32'h3300_0000 + k) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL stray_line: got %0d bad words want 0", errs); end
  endtask

  task automatic test_evict_no_miss();
    int errs;
    clear_logs();
    @(negedge clk);
    bus.i_miss = 1'b0; bus.i_evict = 1'b1; bus.i_evict_addr = 32'h0000_1000;
    errs = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_mem_req !== 1'b0 || bus.o_busy !== 1'b0) errs++;
    end
    bus.i_evict = 1'b0;
    $display("evict_no_miss: 6 cycles observed");
    total++; if (errs != 0) begin bad++; $display("FAIL nomiss_idle: got %0d active cycles want 0", errs); end
    total++; if (wr_addr.size() != 0 || rd_addr.size() != 0) begin bad++; $display("FAIL nomiss_beats: got wr %0d rd %0d want 0 0", wr_addr.size(), rd_addr.size()); end
  endtask

  initial begin
    bus.i_miss = 1'b0; bus.i_miss_addr = '0;
    bus.i_evict = 1'b0; bus.i_evict_addr = '0; bus.i_evict_data = '0;
    bus.i_mem_ready = 1'b0; bus.i_mem_rdata = '0; bus.i_mem_rvalid = 1'b0;
    clear_logs();
    test_reset();
    test_clean_miss();
    test_evict();
    test_backpressure();
    test_reset_mid_fill();
    test_stray_rvalid();
    test_evict_no_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_line_fill_ctrl.md
Name: cache_line_fill_ctrl

Overview:
- Miss-service stage directly downstream of the 4-way SA cache, between the cache and main memory.
- On a cache miss, optionally writes back the dirty victim line, then fetches the missing line as DATA_WIDTH beats over a narrow memory port.
- Assembles the beats into a full line and returns it to the cache with a one-cycle response pulse (drives the cache's i_memory_line / i_memory_response).

Parameters:
- LINE_SIZE_BYTES, 64, cache line size; LINE_SIZE_BITS = 8*LINE_SIZE_BYTES.
- ADDRESS_WIDTH, 32, byte address width.
- OFFSET_BITS, 6, log2(LINE_SIZE_BYTES); line-aligned address has these bits zero.
- DATA_WIDTH, 32, memory beat width; BEATS = LINE_SIZE_BITS/DATA_WIDTH (16); beat stride DATA_WIDTH/8 bytes.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_miss  in  1  level; cache miss pending, held until response seen.
- i_miss_addr  in  ADDRESS_WIDTH  missing address (offset bits ignored).
- i_evict  in  1  dirty victim must be written back; valid only with i_miss.
- i_evict_addr  in  ADDRESS_WIDTH  victim address (offset bits ignored).
- i_evict_data  in  LINE_SIZE_BITS  victim line.
- o_memory_line  out  LINE_SIZE_BITS  assembled fill line.
- o_memory_response  out  1  one-cycle pulse; o_memory_line valid that cycle.
- o_mem_req  out  1  memory beat request.
- o_mem_we  out  1  1 = write beat, 0 = read beat.
- o_mem_addr  out  ADDRESS_WIDTH  beat byte address.
- o_mem_wdata  out  DATA_WIDTH  write beat data.
- i_mem_ready  in  1  beat accepted when o_mem_req & i_mem_ready.
- i_mem_rdata  in  DATA_WIDTH  read beat data.
- i_mem_rvalid  in  1  read data valid; in order; at least 1 cycle after acceptance.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including o_memory_line. Beat counters and captured registers cleared.
- Reset mid-operation aborts the transfer. Partial line is discarded and no response is issued. A still-pending miss restarts from beat 0 after reset release.
- States: IDLE, WB, FILL, RESP.
- IDLE:
  - i_miss=1: capture fill base = i_miss_addr with offset zeroed.
  - Also if i_evict=1: capture wb base (offset zeroed) and i_evict_data; go to WB.
  - If i_evict=0: go to FILL.
  - i_evict without i_miss is ignored.
- WB:
  - o_mem_req=1, o_mem_we=1.
  - Beat k: o_mem_addr = wb_base + k*(DATA_WIDTH/8); o_mem_wdata = evict_data[k*DATA_WIDTH +: DATA_WIDTH].
  - k advances on acceptance. After beat BEATS-1 is accepted, go to FILL.
  - No read is issued before the last write is accepted.
- FILL, request side:
  - o_mem_we=0. Request counter rq issues addresses fill_base + rq*(DATA_WIDTH/8), one per accepted cycle.
  - o_mem_req drops once BEATS requests are accepted.
- FILL, data side:
  - Independent data counter dq. Each i_mem_rvalid writes i_mem_rdata into line[dq*DATA_WIDTH +: DATA_WIDTH], then dq++.
  - When beat BEATS-1 is written, go to RESP next edge.
- RESP: o_memory_response=1 for exactly one cycle, o_memory_line stable, then IDLE.
  - i_miss is sampled again only in IDLE.
  - The cache clears its miss on the response edge, so there is no re-fetch.
- o_memory_line holds its last value until the next fill overwrites it.
- Handshake rules:
  - While o_mem_req=1 and i_mem_ready=0, o_mem_addr, o_mem_we and o_mem_wdata stay stable. The request is never withdrawn.
  - i_mem_ready is ignored while o_mem_req=0.
  - i_mem_rvalid is ignored outside FILL and after dq reaches BEATS.
- Throughput: one beat per cycle with i_mem_ready held high.
- Counters are $clog2(BEATS)+1 bits wide, with no wrap during an operation. Address adds are modulo 2^ADDRESS_WIDTH.
- Changes on i_miss_addr, i_evict_* during an operation are ignored.

Test Plan:
- Clean miss, no evict:
  - Stimulus: i_miss_addr=0x0000_1234, ready=1, rvalid 1 cycle after accept, rdata beat k = 0xA000_0000+k.
  - Response: reads at 0x1200, 0x1204 … 0x123C; one response pulse; o_memory_line[31:0]=0xA0000000, [511:480]=0xA000000F.
- Dirty evict:
  - Stimulus: i_evict_addr=0x0000_8055, evict_data word k = 0xD000_0000+k, miss 0x0000_1200.
  - Response: 16 writes at 0x8040 … 0x807C with matching wdata, then 16 reads from 0x1200; no read before the last write is accepted.
- Backpressure:
  - Stimulus: i_mem_ready toggling 1/0 with random stalls of 1–5 cycles.
  - Response: addr/wdata/we stable during stalls; exactly 16 accepts per phase; line correct.
- Reset mid-fill:
  - Stimulus: rst_n=0 after 5 read beats returned.
  - Response: all outputs 0 immediately; no response pulse; after release, the held miss re-fetches starting at beat 0 (base address).
- Stray rvalid / held miss:
  - Stimulus: rvalid pulses in IDLE and WB; i_miss held through RESP, dropped the cycle after.
  - Response: line unaffected; exactly one fetch and one pulse.
- i_evict=1 with i_miss=0:
  - Response: stays IDLE, o_mem_req=0, o_busy=0.
